// File: rtl/adc_input_common_pkg.sv
// Shared address map, status bit positions and AXI response codes for adc_input.
package adc_input_common;

    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned MAP_ADDR_W = 8;

    localparam logic [MAP_ADDR_W-1:0] AXI_ADDR_CR    = 8'h00;
    localparam logic [MAP_ADDR_W-1:0] AXI_ADDR_DSIZE = 8'h04;
    localparam logic [MAP_ADDR_W-1:0] AXI_ADDR_SR    = 8'h08;
    localparam logic [MAP_ADDR_W-1:0] AXI_ADDR_WCNT  = 8'h0C;
    localparam logic [MAP_ADDR_W-1:0] AXI_ADDR_VER   = 8'h10;

    localparam int unsigned SR_BUSY = 0;
    localparam int unsigned SR_DONE = 1;
    localparam int unsigned SR_OVF  = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/adc_input_read_if.sv
// AXI4-Lite read address/data channel bundle for the adc_input register block.
interface adc_input_read_if;
    import adc_input_common::*;

    logic [AXI_ADDR_W-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [AXI_DATA_W-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output ARADDR, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  ARADDR, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/adc_input_sticky.sv
// Single sticky flag: set wins over a coincident clear, synchronous active-low reset.
module adc_input_sticky (
    input  logic clk,
    input  logic rst_n,
    input  logic set_i,
    input  logic clr_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (set_i) begin
            q_d = 1'b1;
        end else if (clr_i) begin
            q_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/adc_input_read.sv
// AXI4-Lite read slave for adc_input: register readback plus sticky done/overflow flags.
// Define ADC_INPUT_READ_SLVERR_EN to answer unmapped offsets with SLVERR instead of OKAY.
module adc_input_read
    import adc_input_common::*;
#(
    parameter int unsigned DEC_W   = 8,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    adc_input_read_if.slave       axi,
    input  logic [AXI_DATA_W-1:0] dsize,
    input  logic                  cr_test,
    input  logic                  busy,
    input  logic                  done_pulse,
    input  logic                  ovf_pulse,
    input  logic [AXI_DATA_W-1:0] wcnt
);

    rd_state_e             state_q;
    logic [DEC_W-1:0]      addr_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [AXI_DATA_W-1:0] rdata_q;
    logic [1:0]            rresp_d;
    logic [AXI_DATA_W-1:0] rdata_d;
    logic                  sr_done;
    logic                  sr_ovf;
    logic                  sr_clr_c;

    // Reading SR acknowledges both flags on the data handshake.
    assign sr_clr_c = (state_q == S_DATA) && axi.RREADY && (addr_q == DEC_W'(AXI_ADDR_SR));

    adc_input_sticky u_sticky_done (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .set_i (done_pulse),
        .clr_i (sr_clr_c),
        .q_o   (sr_done)
    );

    adc_input_sticky u_sticky_ovf (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .set_i (ovf_pulse),
        .clr_i (sr_clr_c),
        .q_o   (sr_ovf)
    );

    // Register decode of the latched offset; the result is captured once in S_ADDR.
    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_OKAY;
        case (addr_q)
            DEC_W'(AXI_ADDR_CR):    rdata_d = {30'b0, cr_test, 1'b0};
            DEC_W'(AXI_ADDR_DSIZE): rdata_d = dsize;
            DEC_W'(AXI_ADDR_SR): begin
                rdata_d[SR_BUSY] = busy;
                rdata_d[SR_DONE] = sr_done;
                rdata_d[SR_OVF]  = sr_ovf;
            end
            DEC_W'(AXI_ADDR_WCNT):  rdata_d = wcnt;
            DEC_W'(AXI_ADDR_VER):   rdata_d = VERSION;
            default: begin
`ifdef ADC_INPUT_READ_SLVERR_EN
                rresp_d = RESP_SLVERR;
`else
                rresp_d = RESP_OKAY;
`endif
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (axi.ARVALID) begin
                        addr_q    <= axi.ARADDR[DEC_W-1:0];
                        arready_q <= 1'b1;
                        state_q   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    rdata_q   <= rdata_d;
                    rresp_q   <= rresp_d;
                    state_q   <= S_DATA;
                end
                S_DATA: begin
                    if (axi.RREADY) begin
                        rvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign axi.ARREADY = arready_q;
    assign axi.RVALID  = rvalid_q;
    assign axi.RDATA   = rdata_q;
    assign axi.RRESP   = rresp_q;

endmodule
